uart_rx_fifo_ctrl: RTL and testbench
====================================

// Module: uart_rx_fifo_ctrl
// PURPOSE
//  Sequences the UART receiver: drains each received byte into a DEPTH-entry FIFO, pulses
//  the receiver's read/clear input, and gates the RTS pin on FIFO fill level.
//  Sits between the receiver and the CPU peripheral bus.
//  Provides a show-ahead pop interface, a fill level and a sticky overrun flag.
// PARAMETERS
//  PAYLOAD_BITS   8          data bits per byte; matches the receiver
//  DEPTH          4          FIFO entries; power of 2, >= 2
//  RTS_THRESHOLD  DEPTH-1    uart_rts is forced high (not ready) when level >= this
// PORTS
//  clk          in   1              system clock
//  reset        in   1              asynchronous reset, active-high
//  rx_valid     in   1              receiver holds a byte (receiver in READY state)
//  rx_data      in   PAYLOAD_BITS   receiver byte; stable while rx_valid
//  rx_read      out  1              one-cycle pulse: byte taken, receiver returns to IDLE
//  rx_rts       in   1              receiver's own RTS (active low)
//  uart_rts     out  1              RTS to pin (active low) = rx_rts | fill gate
//  data_rd      in   1              pop head entry (ignored when empty)
//  data_out     out  PAYLOAD_BITS   FIFO head; valid when data_avail
//  data_avail   out  1              FIFO not empty
//  level        out  $clog2(DEPTH)+1  entries held, 0..DEPTH
//  overrun      out  1              sticky: receiver stalled on a full FIFO
//  overrun_clr  in   1              clear overrun
//  flush        in   1              empty the FIFO
// BEHAVIOUR
//  Reset (async, immediate): FSM=IDLE, rd/wr ptr=0, level=0, storage=0, rx_read=0,
//   overrun=0, uart_rts=1, data_avail=0, data_out=0.
//  FSM (rx_read is a Moore output of ACK; it is high only in ACK):
//   IDLE : rx_valid & !full -> write rx_data at wr_ptr this edge, go to ACK.
//          rx_valid & full  -> go to STALL, set overrun. Otherwise stay in IDLE.
//   ACK  : rx_read=1 for exactly one cycle; go to IDLE unconditionally.
//          rx_valid is low again on the cycle after ACK, so there is no double capture.
//   STALL: !full -> write rx_data, go to ACK. Otherwise stay in STALL.
//  Latency: rx_valid rise -> write at the same edge (when not full); rx_read the next cycle.
//   data_avail rises the cycle after the write edge.
//  Throughput: one byte per 2 cycles, far above the UART rate.
//  Pop: data_rd & data_avail -> rd_ptr++ at the edge. data_out is combinational from storage[rd_ptr].
//  Push and pop in the same cycle: both occur, level unchanged. Allowed when full
//   (a pop frees space, but STALL only writes on a later cycle when !full).
//  Pointers are $clog2(DEPTH) bits and wrap naturally. level is a separate counter:
//   +1 on push only, -1 on pop only, never outside 0..DEPTH.
//  full = (level==DEPTH); data_avail = (level!=0).
//  flush: rd_ptr=wr_ptr=0, level=0 at the edge. It overrides any push/pop in that cycle.
//   A capture in that cycle still proceeds to ACK, so the byte is discarded but acknowledged.
//   The FSM is otherwise unaffected.
//  overrun: set at the IDLE->STALL transition. overrun_clr clears it.
//   Set wins over clear in the same cycle.
//  uart_rts: registered; next = rx_rts | (level_next >= RTS_THRESHOLD).
//  Reset mid-handshake: rx_read drops immediately. A byte held by the receiver is
//   recaptured after reset only if the receiver itself was not reset.
// TESTING
//  1 reset, rx_valid=1 with rx_data=8'hA5 for 2 cycles, then valid drops after rx_read
//    -> one rx_read pulse; level=1; data_out=A5; data_avail=1.
//  2 push 4 bytes 01..04 with DEPTH=4 -> uart_rts=1 once level>=3; pop 4 times -> 01,02,03,04
//    in order; level returns to 0; data_avail=0.
//  3 fill to 4; present 8'h55 -> STALL, overrun=1, rx_read stays 0; one pop -> write 55,
//    rx_read pulse, level=4; FIFO drains 02,03,04,55.
//  4 level=2; push and pop in the same cycle -> level stays 2; ptr wrap past 3->0
//    keeps FIFO order.
//  5 flush in the same cycle as a capture of 8'h77 -> level=0, rx_read still pulses,
//    data_avail=0.
//  6 overrun_clr concurrent with a new IDLE->STALL -> overrun stays 1; pop on empty
//    -> no change to level or pointers.
//  7 assert reset while in ACK -> rx_read=0 and uart_rts=1 before the next clk edge;
//    level=0.

Source files
------------

// File: rtl/uart_rx_fifo_ctrl.sv
// uart_rx_fifo_ctrl: drains bytes from the UART receiver into a small show-ahead FIFO,
// acknowledges each byte back to the receiver and throttles RTS on the fill level.
module uart_rx_fifo_ctrl #(
  parameter int PAYLOAD_BITS  = 8,
  parameter int DEPTH         = 4,
  parameter int RTS_THRESHOLD = DEPTH - 1
) (
  input  logic                    clk,
  input  logic                    reset,
  input  logic                    rx_valid,
  input  logic [PAYLOAD_BITS-1:0] rx_data,
  output logic                    rx_read,
  input  logic                    rx_rts,
  output logic                    uart_rts,
  input  logic                    data_rd,
  output logic [PAYLOAD_BITS-1:0] data_out,
  output logic                    data_avail,
  output logic [$clog2(DEPTH):0]  level,
  output logic                    overrun,
  input  logic                    overrun_clr,
  input  logic                    flush
);

  localparam int AW = $clog2(DEPTH);
  localparam int LW = AW + 1;
  localparam logic [LW-1:0] LVL_FULL = LW'(DEPTH);
  localparam logic [LW-1:0] LVL_RTS  = LW'(RTS_THRESHOLD);
  localparam logic [LW-1:0] LVL_ONE  = LW'(1);
  localparam logic [LW-1:0] LVL_ZERO = LW'(0);
  localparam logic [AW-1:0] PTR_ONE  = AW'(1);
  localparam logic [AW-1:0] PTR_ZERO = AW'(0);

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_ACK   = 2'd1,
    ST_STALL = 2'd2
  } state_e;

  state_e                  state_q, state_d;
  logic                    rx_read_q, rx_read_d;
  logic                    overrun_q, overrun_d;
  logic                    uart_rts_q, uart_rts_d;
  logic                    data_avail_q, data_avail_d;
  logic [AW-1:0]           wr_ptr_q, wr_ptr_d;
  logic [AW-1:0]           rd_ptr_q, rd_ptr_d;
  logic [LW-1:0]           level_q, level_d;
  logic [PAYLOAD_BITS-1:0] mem_q [DEPTH];

  logic full_s;
  logic push_s;
  logic pop_s;
  logic mem_we_s;
  logic ovr_set_s;

  // Receiver handshake: capture, acknowledge, or wait for room when full.
  always_comb begin
    full_s    = (level_q == LVL_FULL);
    pop_s     = data_rd && (level_q != LVL_ZERO);
    push_s    = 1'b0;
    ovr_set_s = 1'b0;
    state_d   = state_q;
    case (state_q)
      ST_IDLE: begin
        if (rx_valid && !full_s) begin
          push_s  = 1'b1;
          state_d = ST_ACK;
        end else if (rx_valid) begin
          ovr_set_s = 1'b1;
          state_d   = ST_STALL;
        end else begin
          state_d = ST_IDLE;
        end
      end
      ST_ACK: begin
        state_d = ST_IDLE;
      end
      ST_STALL: begin
        if (!full_s) begin
          push_s  = 1'b1;
          state_d = ST_ACK;
        end else begin
          state_d = ST_STALL;
        end
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase
    rx_read_d = (state_d == ST_ACK);
    // A new stall outranks a simultaneous clear so the event is never lost.
    if (ovr_set_s) begin
      overrun_d = 1'b1;
    end else if (overrun_clr) begin
      overrun_d = 1'b0;
    end else begin
      overrun_d = overrun_q;
    end
  end

  // Pointer and level bookkeeping; flush overrides any push or pop.
  always_comb begin
    mem_we_s = push_s && !flush;
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    level_d  = level_q;
    if (flush) begin
      wr_ptr_d = PTR_ZERO;
      rd_ptr_d = PTR_ZERO;
      level_d  = LVL_ZERO;
    end else begin
      if (push_s) begin
        wr_ptr_d = wr_ptr_q + PTR_ONE;
      end else begin
        wr_ptr_d = wr_ptr_q;
      end
      if (pop_s) begin
        rd_ptr_d = rd_ptr_q + PTR_ONE;
      end else begin
        rd_ptr_d = rd_ptr_q;
      end
      if (push_s && !pop_s) begin
        level_d = level_q + LVL_ONE;
      end else if (pop_s && !push_s) begin
        level_d = level_q - LVL_ONE;
      end else begin
        level_d = level_q;
      end
    end
    uart_rts_d   = rx_rts || (level_d >= LVL_RTS);
    data_avail_d = (level_d != LVL_ZERO);
  end

  // Handshake state and its registered outputs.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q   <= ST_IDLE;
      rx_read_q <= 1'b0;
      overrun_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      rx_read_q <= rx_read_d;
      overrun_q <= overrun_d;
    end
  end

  // FIFO control registers and flow-control output.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      wr_ptr_q     <= PTR_ZERO;
      rd_ptr_q     <= PTR_ZERO;
      level_q      <= LVL_ZERO;
      uart_rts_q   <= 1'b1;
      data_avail_q <= 1'b0;
    end else begin
      wr_ptr_q     <= wr_ptr_d;
      rd_ptr_q     <= rd_ptr_d;
      level_q      <= level_d;
      uart_rts_q   <= uart_rts_d;
      data_avail_q <= data_avail_d;
    end
  end

  // Byte storage; a byte captured during a flush is acknowledged but dropped.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      for (int i = 0; i < DEPTH; i++) begin
        mem_q[i] <= {PAYLOAD_BITS{1'b0}};
      end
    end else if (mem_we_s) begin
      mem_q[wr_ptr_q] <= rx_data;
    end
  end

  assign rx_read    = rx_read_q;
  assign overrun    = overrun_q;
  assign uart_rts   = uart_rts_q;
  assign data_avail = data_avail_q;
  assign level      = level_q;
  assign data_out   = mem_q[rd_ptr_q];

endmodule

// File: tb/tb_uart_rx_fifo_ctrl.sv
// Bench for uart_rx_fifo_ctrl: directed scenarios plus a randomized run, all checked
// against a queue-based model of the receiver handshake and FIFO.
module tb_uart_rx_fifo_ctrl;
  localparam int DEPTH = 4;

  logic       clk = 1'b0;
  logic       reset, rx_valid, rx_read, rx_rts, uart_rts;
  logic       data_rd, data_avail, overrun, overrun_clr, flush;
  logic [7:0] rx_data, data_out;
  logic [2:0] level;

  int errors = 0;
  int checks = 0;

  logic [7:0] q[$];
  bit m_ack, m_stall, m_ovr, m_rts, just_dropped;

  uart_rx_fifo_ctrl #(.PAYLOAD_BITS(8), .DEPTH(DEPTH), .RTS_THRESHOLD(DEPTH - 1)) dut (
    .clk(clk), .reset(reset), .rx_valid(rx_valid), .rx_data(rx_data), .rx_read(rx_read),
    .rx_rts(rx_rts), .uart_rts(uart_rts), .data_rd(data_rd), .data_out(data_out),
    .data_avail(data_avail), .level(level), .overrun(overrun), .overrun_clr(overrun_clr),
    .flush(flush)
  );

  always #5 clk = ~clk;

  task automatic mdl_reset();
    q.delete();
    m_ack = 1'b0; m_stall = 1'b0; m_ovr = 1'b0; m_rts = 1'b1; just_dropped = 1'b0;
  endtask

  // One clock: model the edge from the inputs, emulate the receiver dropping valid after ack.
  task automatic tick();
    int sz;
    bit full, cap, setovr, pop, was_ack, stall_n;
    logic [7:0] byte_in;
    sz = q.size(); full = (sz == DEPTH); cap = 1'b0; setovr = 1'b0;
    if (!m_ack) begin
      if (m_stall) cap = !full;
      else if (rx_valid) begin
        if (!full) cap = 1'b1; else setovr = 1'b1;
      end
    end
    stall_n = !cap && (m_stall || setovr);
    pop = data_rd && (sz != 0);
    was_ack = m_ack; byte_in = rx_data;
    @(posedge clk); #1;
    if (flush) q.delete();
    else begin
      if (pop) void'(q.pop_front());
      if (cap) q.push_back(byte_in);
    end
    m_ack = cap; m_stall = stall_n;
    if (setovr) m_ovr = 1'b1; else if (overrun_clr) m_ovr = 1'b0;
    m_rts = rx_rts || (q.size() >= DEPTH - 1);
    just_dropped = was_ack;
    if (was_ack) rx_valid = 1'b0;
    data_rd = 1'b0; flush = 1'b0; overrun_clr = 1'b0;
  endtask

  task automatic push_byte(input logic [7:0] b);
    rx_valid = 1'b1; rx_data = b;
    tick(); tick(); tick();
  endtask

  task automatic test_reset();
    reset = 1'b1; rx_valid = 1'b0; rx_data = 8'h00; rx_rts = 1'b0;
    data_rd = 1'b0; overrun_clr = 1'b0; flush = 1'b0;
    mdl_reset();
    repeat (2) @(posedge clk);
    #1;
    checks++; if (rx_read !== 1'b0) begin errors++; $display("FAIL reset_rx_read: got %b want 0", rx_read); end
    checks++; if (uart_rts !== 1'b1) begin errors++; $display("FAIL reset_uart_rts: got %b want 1", uart_rts); end
    checks++; if (level !== 3'd0) begin errors++; $display("FAIL reset_level: got %0d want 0", level); end
    checks++; if (data_avail !== 1'b0) begin errors++; $display("FAIL reset_avail: got %b want 0", data_avail); end
    checks++; if (data_out !== 8'h00) begin errors++; $display("FAIL reset_data_out: got %h want 00", data_out); end
    checks++; if (overrun !== 1'b0) begin errors++; $display("FAIL reset_overrun: got %b want 0", overrun); end
    reset = 1'b0;
  endtask

  task automatic test_single_byte();
    int pulses = 0;
    rx_valid = 1'b1; rx_data = 8'hA5;
    tick();
    if (rx_read === 1'b1) pulses++;
    checks++; if (rx_read !== 1'b1) begin errors++; $display("FAIL t1_rx_read_latency: got %b want 1", rx_read); end
    checks++; if (level !== 3'd1) begin errors++; $display("FAIL t1_level_after_write: got %0d want 1", level); end
    checks++; if (data_avail !== 1'b1) begin errors++; $display("FAIL t1_avail: got %b want 1", data_avail); end
    repeat (3) begin
      tick();
      if (rx_read === 1'b1) pulses++;
    end
    checks++; if (pulses != 1) begin errors++; $display("FAIL t1_pulse_count: got %0d want 1", pulses); end
    checks++; if (level !== 3'd1) begin errors++; $display("FAIL t1_level: got %0d want 1", level); end
    checks++; if (data_out !== 8'hA5) begin errors++; $display("FAIL t1_data_out: got %h want a5", data_out); end
  endtask

  task automatic test_fill_drain();
    flush = 1'b1; tick();
    for (int i = 0; i < 4; i++) begin
      push_byte(8'(i + 1));
      checks++; if (level !== 3'(i + 1)) begin errors++; $display("FAIL t2_level_push%0d: got %0d want %0d", i, level, i + 1); end
      checks++; if (uart_rts !== (i + 1 >= 3)) begin errors++; $display("FAIL t2_rts_push%0d: got %b want %b", i, uart_rts, (i + 1 >= 3)); end
    end
    for (int i = 0; i < 4; i++) begin
      checks++; if (data_out !== 8'(i + 1)) begin errors++; $display("FAIL t2_order%0d: got %h want %h", i, data_out, 8'(i + 1)); end
      data_rd = 1'b1; tick();
    end
    checks++; if (level !== 3'd0) begin errors++; $display("FAIL t2_level_empty: got %0d want 0", level); end
    checks++; if (data_avail !== 1'b0) begin errors++; $display("FAIL t2_avail_empty: got %b want 0", data_avail); end
    checks++; if (uart_rts !== 1'b0) begin errors++; $display("FAIL t2_rts_empty: got %b want 0", uart_rts); end
  endtask

  task automatic test_stall_overrun();
    logic [7:0] exp_b [4];
    exp_b[0] = 8'h02; exp_b[1] = 8'h03; exp_b[2] = 8'h04; exp_b[3] = 8'h55;
    for (int i = 0; i < 4; i++) push_byte(8'(i + 1));
    rx_valid = 1'b1; rx_data = 8'h55;
    tick();
    checks++; if (overrun !== 1'b1) begin errors++; $display("FAIL t3_overrun_set: got %b want 1", overrun); end
    tick(); tick();
    checks++; if (rx_read !== 1'b0) begin errors++; $display("FAIL t3_no_read_stall: got %b want 0", rx_read); end
    checks++; if (level !== 3'd4) begin errors++; $display("FAIL t3_level_stall: got %0d want 4", level); end
    data_rd = 1'b1; tick();
    checks++; if (level !== 3'd3) begin errors++; $display("FAIL t3_level_pop: got %0d want 3", level); end
    tick();
    checks++; if (rx_read !== 1'b1) begin errors++; $display("FAIL t3_read_after_room: got %b want 1", rx_read); end
    checks++; if (level !== 3'd4) begin errors++; $display("FAIL t3_level_refill: got %0d want 4", level); end
    tick(); tick();
    for (int i = 0; i < 4; i++) begin
      checks++; if (data_out !== exp_b[i]) begin errors++; $display("FAIL t3_drain%0d: got %h want %h", i, data_out, exp_b[i]); end
      data_rd = 1'b1; tick();
    end
  endtask

  task automatic test_push_pop_same();
    logic [7:0] exp_b [6];
    for (int i = 0; i < 6; i++) exp_b[i] = 8'(8'h20 + i);
    push_byte(8'h20); push_byte(8'h21);
    for (int i = 0; i < 4; i++) begin
      checks++; if (data_out !== exp_b[i]) begin errors++; $display("FAIL t4_head%0d: got %h want %h", i, data_out, exp_b[i]); end
      rx_valid = 1'b1; rx_data = exp_b[i + 2]; data_rd = 1'b1;
      tick();
      checks++; if (level !== 3'd2) begin errors++; $display("FAIL t4_level_pp%0d: got %0d want 2", i, level); end
      tick(); tick();
    end
    for (int i = 4; i < 6; i++) begin
      checks++; if (data_out !== exp_b[i]) begin errors++; $display("FAIL t4_wrap%0d: got %h want %h", i, data_out, exp_b[i]); end
      data_rd = 1'b1; tick();
    end
    checks++; if (level !== 3'd0) begin errors++; $display("FAIL t4_level_end: got %0d want 0", level); end
  endtask

  task automatic test_flush_capture();
    push_byte(8'h30);
    rx_valid = 1'b1; rx_data = 8'h77; flush = 1'b1;
    tick();
    checks++; if (level !== 3'd0) begin errors++; $display("FAIL t5_level: got %0d want 0", level); end
    checks++; if (rx_read !== 1'b1) begin errors++; $display("FAIL t5_rx_read: got %b want 1", rx_read); end
    checks++; if (data_avail !== 1'b0) begin errors++; $display("FAIL t5_avail: got %b want 0", data_avail); end
    tick(); tick();
    checks++; if (level !== 3'd0) begin errors++; $display("FAIL t5_level_after: got %0d want 0", level); end
  endtask

  task automatic test_overrun_clr();
    overrun_clr = 1'b1; tick();
    checks++; if (overrun !== 1'b0) begin errors++; $display("FAIL t6_clear: got %b want 0", overrun); end
    for (int i = 0; i < 4; i++) push_byte(8'(8'h40 + i));
    rx_valid = 1'b1; rx_data = 8'h66; overrun_clr = 1'b1;
    tick();
    checks++; if (overrun !== 1'b1) begin errors++; $display("FAIL t6_set_wins: got %b want 1", overrun); end
    checks++; if (rx_read !== 1'b0) begin errors++; $display("FAIL t6_no_read: got %b want 0", rx_read); end
    overrun_clr = 1'b1; tick();
    checks++; if (overrun !== 1'b0) begin errors++; $display("FAIL t6_clear_in_stall: got %b want 0", overrun); end
    repeat (8) begin
      data_rd = (q.size() != 0);
      tick();
    end
    checks++; if (level !== 3'd0) begin errors++; $display("FAIL t6_drained: got %0d want 0", level); end
    data_rd = 1'b1; tick();
    checks++; if (level !== 3'd0) begin errors++; $display("FAIL t6_pop_empty_level: got %0d want 0", level); end
    checks++; if (data_avail !== 1'b0) begin errors++; $display("FAIL t6_pop_empty_avail: got %b want 0", data_avail); end
    push_byte(8'h5A);
    checks++; if (data_out !== 8'h5A) begin errors++; $display("FAIL t6_ptr_intact: got %h want 5a", data_out); end
    checks++; if (level !== 3'd1) begin errors++; $display("FAIL t6_level_one: got %0d want 1", level); end
    flush = 1'b1; tick();
  endtask

  task automatic test_reset_mid_ack();
    rx_valid = 1'b1; rx_data = 8'h99;
    tick();
    checks++; if (rx_read !== 1'b1) begin errors++; $display("FAIL t7_in_ack: got %b want 1", rx_read); end
    #1 reset = 1'b1;
    mdl_reset();
    #1;
    checks++; if (rx_read !== 1'b0) begin errors++; $display("FAIL t7_rx_read_async: got %b want 0", rx_read); end
    checks++; if (uart_rts !== 1'b1) begin errors++; $display("FAIL t7_rts_async: got %b want 1", uart_rts); end
    checks++; if (level !== 3'd0) begin errors++; $display("FAIL t7_level: got %0d want 0", level); end
    #1 reset = 1'b0;
    tick();
    checks++; if (rx_read !== 1'b1) begin errors++; $display("FAIL t7_recapture: got %b want 1", rx_read); end
    checks++; if (data_out !== 8'h99) begin errors++; $display("FAIL t7_recapture_data: got %h want 99", data_out); end
    tick(); tick();
    flush = 1'b1; tick();
  endtask

  task automatic test_random();
    int rd_pct;
    for (int i = 0; i < 800; i++) begin
      rd_pct = (i < 400) ? 1 : 5;
      if (!rx_valid && !just_dropped && $urandom_range(0, 2) == 0) begin
        rx_valid = 1'b1; rx_data = 8'($urandom);
      end
      data_rd     = ($urandom_range(0, 9) < rd_pct);
      flush       = ($urandom_range(0, 39) == 0);
      overrun_clr = ($urandom_range(0, 15) == 0);
      rx_rts      = ($urandom_range(0, 7) == 0);
      tick();
      checks++; if (rx_read !== m_ack) begin errors++; $display("FAIL rnd_rx_read@%0d: got %b want %b", i, rx_read, m_ack); end
      checks++; if (level !== 3'(q.size())) begin errors++; $display("FAIL rnd_level@%0d: got %0d want %0d", i, level, q.size()); end
      checks++; if (data_avail !== (q.size() != 0)) begin errors++; $display("FAIL rnd_avail@%0d: got %b want %b", i, data_avail, (q.size() != 0)); end
      checks++; if (overrun !== m_ovr) begin errors++; $display("FAIL rnd_overrun@%0d: got %b want %b", i, overrun, m_ovr); end
      checks++; if (uart_rts !== m_rts) begin errors++; $display("FAIL rnd_rts@%0d: got %b want %b", i, uart_rts, m_rts); end
      if (q.size() != 0) begin
        checks++; if (data_out !== q[0]) begin errors++; $display("FAIL rnd_data_out@%0d: got %h want %h", i, data_out, q[0]); end
      end
    end
    rx_rts = 1'b0;
  endtask

  initial begin
    test_reset();
    test_single_byte();
    test_fill_drain();
    test_stall_overrun();
    test_push_pop_same();
    test_flush_capture();
    test_overrun_clr();
    test_reset_mid_ack();
    test_random();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
